data_mem_arbiter: RTL and testbench
===================================

# data_mem_arbiter

Two-port arbiter and access sequencer for the 2048 x 16 data memory. It shares the single memory port between the CPU datapath (port A) and the debug/UART dump unit (port B) using round-robin arbitration. It converts each granted request into a clean setup/strobe/hold sequence on the memory's level-sensitive read and write strobes, returns read data, and issues a one-cycle acknowledge to the requester.

## Interface
Parameters:
- ADDR_W, 11, memory address width
- DATA_W, 16, memory word width

Ports:
- clk  in  1  system clock; all state changes on rising edge
- rst_n  in  1  reset, asynchronous assert, active-low
- a_req  in  1  port A request; held high until a_ack
- a_we  in  1  port A: 1 = write, 0 = read; sampled at grant
- a_addr  in  ADDR_W  port A word address; sampled at grant
- a_wdata  in  DATA_W  port A write data; sampled at grant
- a_ack  out  1  one-cycle completion pulse to A
- a_rdata  out  DATA_W  last read word for A, valid from a_ack, held until A's next read completes
- b_req, b_we, b_addr, b_wdata, b_ack, b_rdata: same as port A, for port B
- mem_rd  out  1  memory read strobe (RdRam)
- mem_wr  out  1  memory write strobe (WrRam)
- mem_addr  out  ADDR_W  memory address (Addr)
- mem_wdata  out  DATA_W  memory write data (In_Data)
- mem_rdata  in  DATA_W  memory read data (Out_Data)
- busy  out  1  high in any state except IDLE
- owner  out  1  port of current/last grant: 0 = A, 1 = B

## Operation
- States: IDLE, SETUP, STROBE, DONE. All outputs are registered.
- IDLE:
  - No req: stay in IDLE.
  - One req: grant that port.
  - Both req: grant the port not equal to `last`.
  - On grant: latch we, addr, and wdata into mem_addr, mem_wdata, and an internal we_q; set owner; set last = granted port; go to SETUP.
- SETUP: mem_addr and mem_wdata stable, strobes low. Go to STROBE.
- STROBE:
  - Assert mem_wr if we_q, else mem_rd, for exactly one cycle.
  - On a read, capture mem_rdata into the owner's rdata register at the end of this cycle.
  - Go to DONE.
- DONE:
  - Strobes low; mem_addr and mem_wdata still held.
  - Pulse the owner's ack for this cycle only.
  - Go to IDLE.
- mem_rd and mem_wr are never high together and never high outside STROBE.
- mem_addr and mem_wdata change only on a grant edge. They hold their values in IDLE.
- A req is sampled only in IDLE. A req that stays high in the IDLE cycle after its ack is a new request.
- The non-granted port's req is ignored until the next IDLE. There is no starvation: with both ports requesting continuously, grants alternate A, B, A, B.
- Reset values:
  - state = IDLE
  - last = B, so A wins the first contention
  - owner = 0
  - all acks, strobes, busy = 0
  - mem_addr, mem_wdata, a_rdata, b_rdata = 0

## Timing
- req high in IDLE at cycle t produces: SETUP at t+1, strobe at t+2, ack at t+3. Request-to-ack latency is 3 cycles.
- Back-to-back throughput is one transaction per 4 cycles, because IDLE is always visited between transactions.
- Address setup before the strobe rising is 1 cycle. Address and data hold after the strobe falling is at least 1 cycle (DONE).
- rdata is updated at the rising edge that ends STROBE and is valid in the same cycle as ack.
- Reset mid-transaction: all strobes and acks drop immediately (asynchronous). The transaction is abandoned with no ack. A write strobe already issued may have written memory. The requester must reissue.
- A req dropped before grant: never granted and never acked. A req dropped after grant: the transaction completes and ack is still pulsed.

## Test plan
- Single A read at addr 0x005, memory preloaded with Mem[i] = i: mem_rd is high in exactly cycle t+2, a_ack in t+3, a_rdata = 0x0005. mem_wr stays low throughout.
- Single B write of 0xBEEF to 0x7FF, then B read of 0x7FF: mem_wr pulses once with mem_addr = 0x7FF and mem_wdata = 0xBEEF. The read returns b_rdata = 0xBEEF and a_rdata is unchanged.
- A and B both request from reset (A read 0x010, B read 0x020): A is served first (a_rdata = 0x0010), then B (b_rdata = 0x0020). Acks are 4 cycles apart and owner goes 0 then 1.
- Both ports hold req continuously for 8 transactions: grants alternate A, B, A, B; each port gets 4 acks. Strobes are never simultaneous and never outside STROBE.
- Assert rst_n = 0 during STROBE of an A write: mem_wr and busy drop immediately and no a_ack is issued. After release, all outputs are 0 and state is IDLE. A reissued read at the same address completes normally.
- mem_addr hold check: a write to 0x100 followed by a read from 0x200. mem_addr stays 0x100 through DONE and into IDLE, and changes only on the next grant edge.

Source files
------------

// File: rtl/data_mem_arbiter.sv
// Round-robin sharing of the 2048x16 data memory between the CPU (A)
// and the debug dump unit (B), with setup/strobe/hold access sequencing.
module data_mem_arbiter #(
    parameter int ADDR_W = 11,
    parameter int DATA_W = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              a_req,
    input  logic              a_we,
    input  logic [ADDR_W-1:0] a_addr,
    input  logic [DATA_W-1:0] a_wdata,
    output logic              a_ack,
    output logic [DATA_W-1:0] a_rdata,
    input  logic              b_req,
    input  logic              b_we,
    input  logic [ADDR_W-1:0] b_addr,
    input  logic [DATA_W-1:0] b_wdata,
    output logic              b_ack,
    output logic [DATA_W-1:0] b_rdata,
    output logic              mem_rd,
    output logic              mem_wr,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic              busy,
    output logic              owner
);

    typedef enum logic [1:0] {
        IDLE,
        SETUP,
        STROBE,
        DONE
    } state_t;

    state_t state_q;
    state_t state_d;

    logic last_q;
    logic we_q;
    logic grant;
    logic grant_b;
    logic rd_d;
    logic wr_d;
    logic a_ack_d;
    logic b_ack_d;
    logic busy_d;

    // On contention the port that did not win last time gets the grant.
    always_comb begin
        grant   = a_req | b_req;
        grant_b = (a_req & b_req) ? ~last_q : b_req;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE:    if (grant) state_d = SETUP;
            SETUP:   state_d = STROBE;
            STROBE:  state_d = DONE;
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Outputs are decoded from the next state so they leave a flop.
    always_comb begin
        rd_d    = (state_d == STROBE) && !we_q;
        wr_d    = (state_d == STROBE) && we_q;
        a_ack_d = (state_d == DONE) && !owner;
        b_ack_d = (state_d == DONE) && owner;
        busy_d  = (state_d != IDLE);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mem_rd    <= 1'b0;
            mem_wr    <= 1'b0;
            a_ack     <= 1'b0;
            b_ack     <= 1'b0;
            busy      <= 1'b0;
            owner     <= 1'b0;
            last_q    <= 1'b1;
            we_q      <= 1'b0;
            mem_addr  <= '0;
            mem_wdata <= '0;
            a_rdata   <= '0;
            b_rdata   <= '0;
        end else begin
            mem_rd <= rd_d;
            mem_wr <= wr_d;
            a_ack  <= a_ack_d;
            b_ack  <= b_ack_d;
            busy   <= busy_d;
            if (state_q == IDLE && grant) begin
                owner     <= grant_b;
                last_q    <= grant_b;
                we_q      <= grant_b ? b_we : a_we;
                mem_addr  <= grant_b ? b_addr : a_addr;
                mem_wdata <= grant_b ? b_wdata : a_wdata;
            end
            if (state_q == STROBE && !we_q) begin
                if (owner) begin
                    b_rdata <= mem_rdata;
                end else begin
                    a_rdata <= mem_rdata;
                end
            end
        end
    end

endmodule

// File: tb/tb_data_mem_arbiter.sv
// Bench for data_mem_arbiter: directed vector table, corner sequences
// and randomized transactions against a transaction-level model.
module tb_data_mem_arbiter;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        a_req, a_we, a_ack;
    logic [10:0] a_addr;
    logic [15:0] a_wdata, a_rdata;
    logic        b_req, b_we, b_ack;
    logic [10:0] b_addr;
    logic [15:0] b_wdata, b_rdata;
    logic        mem_rd, mem_wr, busy, owner;
    logic [10:0] mem_addr;
    logic [15:0] mem_wdata, mem_rdata;

    data_mem_arbiter #(.ADDR_W(11), .DATA_W(16)) dut (
        .clk(clk), .rst_n(rst_n),
        .a_req(a_req), .a_we(a_we), .a_addr(a_addr),
        .a_wdata(a_wdata), .a_ack(a_ack), .a_rdata(a_rdata),
        .b_req(b_req), .b_we(b_we), .b_addr(b_addr),
        .b_wdata(b_wdata), .b_ack(b_ack), .b_rdata(b_rdata),
        .mem_rd(mem_rd), .mem_wr(mem_wr), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_rdata(mem_rdata),
        .busy(busy), .owner(owner)
    );

    always #5 clk = ~clk;

    logic [15:0] mem [2048];
    assign mem_rdata = mem[mem_addr];

    logic [15:0] mem_m [2048];
    logic        last_m;
    logic [15:0] rd_m [2];

    int n_assert = 0;
    int n_fail = 0;

    typedef struct packed {
        logic        ra;
        logic        wa;
        logic [10:0] aa;
        logic [15:0] da;
        logic        rb;
        logic        wb;
        logic [10:0] ab;
        logic [15:0] db;
        logic [15:0] exp_a;
        logic [15:0] exp_b;
        logic        exp_owner;
    } vec_t;

    vec_t vecs [7];

    task automatic check(input string name, input logic [31:0] act,
                         input logic [31:0] exp);
        n_assert++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Level-sensitive memory: a write lands while the strobe is high.
    task automatic tick();
        @(negedge clk);
        if (mem_wr) mem[mem_addr] = mem_wdata;
        check("strobe_excl", 32'(mem_rd & mem_wr), 0);
        check("strobe_idle", 32'((mem_rd | mem_wr) & ~busy), 0);
        check("ack_excl", 32'(a_ack & b_ack), 0);
    endtask

    task automatic do_txn(input logic ra, input logic wa,
                          input logic [10:0] aa, input logic [15:0] da,
                          input logic rb, input logic wb,
                          input logic [10:0] ab, input logic [15:0] db);
        logic        pw [2];
        logic [10:0] pa [2];
        logic [15:0] pd [2];
        int ord [2];
        int pos [2];
        int acks [2];
        int n, strobes, idx, p;
        pw[0] = wa; pa[0] = aa; pd[0] = da;
        pw[1] = wb; pa[1] = ab; pd[1] = db;
        pos[0] = -1; pos[1] = -1;
        acks[0] = 0; acks[1] = 0;
        ord[0] = 0; ord[1] = 1;
        n = 0;
        strobes = 0;
        if (ra && rb) begin
            ord[0] = last_m ? 0 : 1;
            ord[1] = 1 - ord[0];
            n = 2;
        end else if (ra) begin
            ord[0] = 0; n = 1;
        end else if (rb) begin
            ord[0] = 1; n = 1;
        end
        for (int i = 0; i < n; i++) pos[ord[i]] = i;
        a_req = ra; a_we = wa; a_addr = aa; a_wdata = da;
        b_req = rb; b_we = wb; b_addr = ab; b_wdata = db;
        for (int k = 1; k <= 11; k++) begin
            tick();
            if (mem_rd | mem_wr) begin
                strobes++;
                idx = (k - 2) / 4;
                if (k < 2 || idx >= n) begin
                    check("strobe_unexpected", k, 0);
                end else begin
                    p = ord[idx];
                    check("strobe_cycle", k, 2 + 4 * idx);
                    check("strobe_we", 32'(mem_wr), 32'(pw[p]));
                    check("strobe_addr", 32'(mem_addr), 32'(pa[p]));
                    if (mem_wr)
                        check("strobe_wdata", 32'(mem_wdata), 32'(pd[p]));
                end
            end
            if (a_ack) begin
                acks[0]++;
                check("a_ack_cycle", k, 3 + 4 * pos[0]);
                a_req = 1'b0;
            end
            if (b_ack) begin
                acks[1]++;
                check("b_ack_cycle", k, 3 + 4 * pos[1]);
                b_req = 1'b0;
            end
        end
        for (int i = 0; i < n; i++) begin
            p = ord[i];
            if (pw[p]) mem_m[pa[p]] = pd[p];
            else rd_m[p] = mem_m[pa[p]];
        end
        if (n > 0) last_m = ord[n-1][0];
        check("a_ack_count", acks[0], 32'(ra));
        check("b_ack_count", acks[1], 32'(rb));
        check("strobe_count", strobes, n);
        check("a_rdata", 32'(a_rdata), 32'(rd_m[0]));
        check("b_rdata", 32'(b_rdata), 32'(rd_m[1]));
        check("owner", 32'(owner), 32'(last_m));
        check("busy_end", 32'(busy), 0);
    endtask

    initial begin
        int cnt, na, nb, prevk, first, p;
        logic [10:0] ra_addr, rb_addr;
        int r;

        vecs[0] = '{1'b1, 1'b0, 11'h005, 16'h0000, 1'b0, 1'b0, 11'h000,
                    16'h0000, 16'h0005, 16'h0000, 1'b0};
        vecs[1] = '{1'b0, 1'b0, 11'h000, 16'h0000, 1'b1, 1'b1, 11'h7FF,
                    16'hBEEF, 16'h0005, 16'h0000, 1'b1};
        vecs[2] = '{1'b0, 1'b0, 11'h000, 16'h0000, 1'b1, 1'b0, 11'h7FF,
                    16'h0000, 16'h0005, 16'hBEEF, 1'b1};
        vecs[3] = '{1'b1, 1'b0, 11'h010, 16'h0000, 1'b1, 1'b0, 11'h020,
                    16'h0000, 16'h0010, 16'h0020, 1'b1};
        vecs[4] = '{1'b1, 1'b1, 11'h100, 16'h1234, 1'b1, 1'b0, 11'h100,
                    16'h0000, 16'h0010, 16'h1234, 1'b1};
        vecs[5] = '{1'b1, 1'b0, 11'h003, 16'h0000, 1'b0, 1'b0, 11'h000,
                    16'h0000, 16'h0003, 16'h1234, 1'b0};
        vecs[6] = '{1'b1, 1'b0, 11'h100, 16'h0000, 1'b1, 1'b1, 11'h100,
                    16'h5678, 16'h5678, 16'h1234, 1'b0};

        for (int i = 0; i < 2048; i++) begin
            mem[i] = 16'(i);
            mem_m[i] = 16'(i);
        end
        last_m = 1'b1;
        rd_m[0] = '0;
        rd_m[1] = '0;

        rst_n = 1'b0;
        a_req = 0; a_we = 0; a_addr = '0; a_wdata = '0;
        b_req = 0; b_we = 0; b_addr = '0; b_wdata = '0;
        repeat (3) tick();
        rst_n = 1'b1;
        tick();
        check("rst_busy", 32'(busy), 0);
        check("rst_owner", 32'(owner), 0);
        check("rst_strobes", 32'({mem_rd, mem_wr}), 0);
        check("rst_acks", 32'({a_ack, b_ack}), 0);
        check("rst_addr", 32'(mem_addr), 0);
        check("rst_wdata", 32'(mem_wdata), 0);
        check("rst_rdata", 32'({a_rdata, b_rdata}), 0);

        for (int i = 0; i < 7; i++) begin
            do_txn(vecs[i].ra, vecs[i].wa, vecs[i].aa, vecs[i].da,
                   vecs[i].rb, vecs[i].wb, vecs[i].ab, vecs[i].db);
            check("vec_a_rdata", 32'(a_rdata), 32'(vecs[i].exp_a));
            check("vec_b_rdata", 32'(b_rdata), 32'(vecs[i].exp_b));
            check("vec_owner", 32'(owner), 32'(vecs[i].exp_owner));
        end

        // Both ports requesting continuously for eight grants.
        ra_addr = 11'($urandom_range(0, 2047));
        rb_addr = 11'($urandom_range(0, 2047));
        first = last_m ? 0 : 1;
        a_req = 1; a_we = 0; a_addr = ra_addr;
        b_req = 1; b_we = 0; b_addr = rb_addr;
        cnt = 0; na = 0; nb = 0; prevk = 0;
        for (int k = 1; k <= 40; k++) begin
            tick();
            if (a_ack | b_ack) begin
                p = b_ack ? 1 : 0;
                if (p == 0) na++; else nb++;
                check("cont_port", p, (cnt % 2 == 0) ? first : 1 - first);
                if (cnt == 0) check("cont_first", k, 3);
                else check("cont_gap", k - prevk, 4);
                if (p == 0)
                    check("cont_a_rdata", 32'(a_rdata), 32'(mem_m[ra_addr]));
                else
                    check("cont_b_rdata", 32'(b_rdata), 32'(mem_m[rb_addr]));
                prevk = k;
                cnt++;
                if (cnt == 8) begin
                    a_req = 0;
                    b_req = 0;
                end
            end
        end
        check("cont_acks", cnt, 8);
        check("cont_a_acks", na, 4);
        check("cont_b_acks", nb, 4);
        rd_m[0] = mem_m[ra_addr];
        rd_m[1] = mem_m[rb_addr];
        last_m = 1'(1 - first);

        // Address/data hold across DONE and IDLE until the next grant.
        a_req = 1; a_we = 1; a_addr = 11'h100; a_wdata = 16'h4321;
        tick(); tick(); tick();
        check("hold_ack", 32'(a_ack), 1);
        check("hold_done_addr", 32'(mem_addr), 32'h100);
        a_req = 0;
        tick();
        check("hold_idle_addr", 32'(mem_addr), 32'h100);
        check("hold_idle_wdata", 32'(mem_wdata), 32'h4321);
        check("hold_idle_busy", 32'(busy), 0);
        a_req = 1; a_we = 0; a_addr = 11'h200;
        tick();
        check("hold_grant_addr", 32'(mem_addr), 32'h200);
        tick(); tick();
        check("hold_rd_ack", 32'(a_ack), 1);
        a_req = 0;
        mem_m[11'h100] = 16'h4321;
        rd_m[0] = mem_m[11'h200];
        last_m = 1'b0;
        check("hold_rdata", 32'(a_rdata), 32'(rd_m[0]));
        tick();

        // Reset during the write strobe abandons the transaction.
        a_req = 1; a_we = 1; a_addr = 11'h050; a_wdata = 16'hAAAA;
        tick(); tick();
        check("rst_wr_on", 32'(mem_wr), 1);
        rst_n = 1'b0;
        #1;
        check("rst_wr_drop", 32'(mem_wr), 0);
        check("rst_busy_drop", 32'(busy), 0);
        check("rst_no_ack", 32'(a_ack), 0);
        a_req = 0;
        tick(); tick();
        check("rst_hold_ack", 32'(a_ack), 0);
        rst_n = 1'b1;
        tick();
        check("rst2_busy", 32'(busy), 0);
        check("rst2_owner", 32'(owner), 0);
        check("rst2_out", 32'({mem_rd, mem_wr, a_ack, b_ack}), 0);
        check("rst2_addr", 32'(mem_addr), 0);
        check("rst2_rdata", 32'({a_rdata, b_rdata}), 0);
        mem_m[11'h050] = 16'hAAAA;
        last_m = 1'b1;
        rd_m[0] = '0;
        rd_m[1] = '0;
        do_txn(1, 0, 11'h050, 16'h0, 0, 0, 11'h0, 16'h0);
        check("rst_reissue", 32'(a_rdata), 32'hAAAA);

        for (int it = 0; it < 40; it++) begin
            r = $urandom_range(1, 3);
            do_txn(r[0], 1'($urandom), 11'($urandom_range(0, 2047)),
                   16'($urandom), r[1], 1'($urandom),
                   11'($urandom_range(0, 2047)), 16'($urandom));
        end

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_assert, n_fail);
        $finish;
    end

endmodule
